// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: default widths, control-word
// bit positions and the ALU control class encodings.
package id_ex_stage_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;
    localparam int CTRL_W      = 7;
    localparam int MEM_CTRL_W  = 4;
    localparam int BUBBLE_W    = 16;

    // i_ctrl = {RegDst, ALUSrc, ShiftSrc, MemRead, MemWrite, MemtoReg, RegWrite}
    localparam int CTRL_REGDST   = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_SHIFTSRC = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 0;

    typedef enum logic [3:0] {
        ALUOP_RTYPE = 4'b0000,
        ALUOP_LDST  = 4'b0001,
        ALUOP_ADDI  = 4'b0010,
        ALUOP_ANDI  = 4'b0011,
        ALUOP_ORI   = 4'b0100,
        ALUOP_XORI  = 4'b0101,
        ALUOP_SLTI  = 4'b0110
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load sitting in EX and the instruction in ID.
// A squashed ID instruction never stalls, since it is about to become a bubble anyway.
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int NB_REG = NB_REG_DEF
) (
    input  logic              i_ex_mem_read,
    input  logic              i_ex_valid,
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic              i_use_rs,
    input  logic              i_use_rt,
    input  logic              i_flush,
    output logic              o_stall
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = i_use_rs && (i_ex_rt == i_id_rs);
        rt_match = i_use_rt && (i_ex_rt == i_id_rt);
        o_stall  = i_ex_mem_read && i_ex_valid && (i_ex_rt != '0)
                   && (rs_match || rt_match) && !i_flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on squash or load-use stall,
// operand muxing toward the ALU, and a saturating bubble counter for the debug unit.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [NB_DATA-1:0]    i_rs_data,
    input  logic [NB_DATA-1:0]    i_rt_data,
    input  logic [NB_DATA-1:0]    i_imm,
    input  logic [NB_REG-1:0]     i_shamt,
    input  logic [NB_REG-1:0]     i_rs,
    input  logic [NB_REG-1:0]     i_rt,
    input  logic [NB_REG-1:0]     i_rd,
    input  logic                  i_use_rs,
    input  logic                  i_use_rt,
    input  logic [3:0]            i_ALUop,
    input  logic [5:0]            i_func,
    input  logic [CTRL_W-1:0]     i_ctrl,
    output logic [NB_DATA-1:0]    o_A,
    output logic [NB_DATA-1:0]    o_B,
    output logic [NB_DATA-1:0]    o_rt_data,
    output logic [NB_REG-1:0]     o_dst,
    output logic [3:0]            o_ALUop,
    output logic [5:0]            o_func,
    output logic [MEM_CTRL_W-1:0] o_mem_ctrl,
    output logic                  o_valid,
    output logic                  o_stall,
    output logic [BUBBLE_W-1:0]   o_bubble_cnt
);

    logic [NB_DATA-1:0]    rs_data_q, rs_data_d;
    logic [NB_DATA-1:0]    rt_data_q, rt_data_d;
    logic [NB_DATA-1:0]    imm_q, imm_d;
    logic [NB_REG-1:0]     shamt_q, shamt_d;
    logic [NB_REG-1:0]     rt_q, rt_d;
    logic [NB_REG-1:0]     rd_q, rd_d;
    alu_op_e               alu_op_q, alu_op_d;
    logic [5:0]            func_q, func_d;
    logic                  reg_dst_q, reg_dst_d;
    logic                  alu_src_q, alu_src_d;
    logic                  shift_src_q, shift_src_d;
    logic [MEM_CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
    logic                  valid_q, valid_d;
    logic [BUBBLE_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic                  stall;

    hazard_detect #(
        .NB_REG (NB_REG)
    ) u_hazard_detect (
        .i_ex_mem_read (mem_ctrl_q[CTRL_MEMREAD]),
        .i_ex_valid    (valid_q),
        .i_ex_rt       (rt_q),
        .i_id_rs       (i_rs),
        .i_id_rt       (i_rt),
        .i_use_rs      (i_use_rs),
        .i_use_rt      (i_use_rt),
        .i_flush       (i_flush),
        .o_stall       (stall)
    );

    always_comb begin
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        shamt_d      = shamt_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        alu_op_d     = alu_op_q;
        func_d       = func_q;
        reg_dst_d    = reg_dst_q;
        alu_src_d    = alu_src_q;
        shift_src_d  = shift_src_q;
        mem_ctrl_d   = mem_ctrl_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;

        if (i_enable) begin
            if (i_flush || stall) begin
                rs_data_d   = '0;
                rt_data_d   = '0;
                imm_d       = '0;
                shamt_d     = '0;
                rt_d        = '0;
                rd_d        = '0;
                alu_op_d    = ALUOP_RTYPE;
                func_d      = '0;
                reg_dst_d   = 1'b0;
                alu_src_d   = 1'b0;
                shift_src_d = 1'b0;
                mem_ctrl_d  = '0;
                valid_d     = 1'b0;
                if (bubble_cnt_q != '1) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end else begin
                rs_data_d   = i_rs_data;
                rt_data_d   = i_rt_data;
                imm_d       = i_imm;
                shamt_d     = i_shamt;
                rt_d        = i_rt;
                rd_d        = i_rd;
                alu_op_d    = alu_op_e'(i_ALUop);
                func_d      = i_func;
                reg_dst_d   = i_ctrl[CTRL_REGDST];
                alu_src_d   = i_ctrl[CTRL_ALUSRC];
                shift_src_d = i_ctrl[CTRL_SHIFTSRC];
                mem_ctrl_d  = i_ctrl[CTRL_MEMREAD:CTRL_REGWRITE];
                valid_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            alu_op_q     <= ALUOP_RTYPE;
            func_q       <= '0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            shift_src_q  <= 1'b0;
            mem_ctrl_q   <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            alu_op_q     <= alu_op_d;
            func_q       <= func_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            shift_src_q  <= shift_src_d;
            mem_ctrl_q   <= mem_ctrl_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Operand muxes look only at registered state, so EX timing never sees ID paths.
    always_comb begin
        o_A = shift_src_q ? {{(NB_DATA-NB_REG){1'b0}}, shamt_q} : rs_data_q;
        o_B = alu_src_q ? imm_q : rt_data_q;
        o_dst = reg_dst_q ? rd_q : rt_q;
    end

    assign o_rt_data    = rt_data_q;
    assign o_ALUop      = alu_op_q;
    assign o_func       = func_q;
    assign o_mem_ctrl   = mem_ctrl_q;
    assign o_valid      = valid_q;
    assign o_stall      = stall;
    assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, randomized run against a
// behavioural model of the EX slot, asynchronous reset and counter saturation.
module tb_id_ex_stage;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_enable;
    logic        i_flush;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_shamt, i_rs, i_rt, i_rd;
    logic        i_use_rs, i_use_rt;
    logic [3:0]  i_ALUop;
    logic [5:0]  i_func;
    logic [6:0]  i_ctrl;
    logic [31:0] o_A, o_B, o_rt_data;
    logic [4:0]  o_dst;
    logic [3:0]  o_ALUop;
    logic [5:0]  o_func;
    logic [3:0]  o_mem_ctrl;
    logic        o_valid, o_stall;
    logic [15:0] o_bubble_cnt;

    always #5 i_clk = ~i_clk;

    id_ex_stage #(.NB_DATA(32), .NB_REG(5)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_flush(i_flush),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_shamt(i_shamt), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_use_rs(i_use_rs), .i_use_rt(i_use_rt), .i_ALUop(i_ALUop), .i_func(i_func),
        .i_ctrl(i_ctrl), .o_A(o_A), .o_B(o_B), .o_rt_data(o_rt_data), .o_dst(o_dst),
        .o_ALUop(o_ALUop), .o_func(o_func), .o_mem_ctrl(o_mem_ctrl), .o_valid(o_valid),
        .o_stall(o_stall), .o_bubble_cnt(o_bubble_cnt)
    );

    typedef struct {
        logic        en, fl;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rs, rt, rd;
        logic        use_rs, use_rt;
        logic [3:0]  alu;
        logic [5:0]  func;
        logic [6:0]  ctrl;
        logic        x_stall;
        logic [31:0] x_a, x_b;
        logic [4:0]  x_dst;
        logic [3:0]  x_mem;
        logic        x_valid;
        logic [15:0] x_cnt;
    } vec_t;

    // Reference model: the instruction occupying EX, or nothing (bubble).
    typedef struct {
        bit          valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rt, rd;
        logic [3:0]  alu;
        logic [5:0]  func;
        logic [6:0]  ctrl;
    } slot_t;

    slot_t ex;
    int    m_cnt;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.rs_data = 0; s.rt_data = 0; s.imm = 0; s.shamt = 0;
        s.rt = 0; s.rd = 0; s.alu = 0; s.func = 0; s.ctrl = 0;
        return s;
    endfunction

    function automatic bit model_stall(input vec_t v);
        bit loads = ex.valid && ex.ctrl[3] && (ex.rt != 0);
        bit dep   = (v.use_rs && v.rs == ex.rt) || (v.use_rt && v.rt == ex.rt);
        return loads && dep && !v.fl;
    endfunction

    task automatic model_edge(input vec_t v, input bit stall);
        if (!v.en) return;
        if (v.fl || stall) begin
            ex = empty_slot();
            if (m_cnt < 65535) m_cnt++;
        end else begin
            ex.valid = 1; ex.rs_data = v.rs_data; ex.rt_data = v.rt_data; ex.imm = v.imm;
            ex.shamt = v.shamt; ex.rt = v.rt; ex.rd = v.rd; ex.alu = v.alu;
            ex.func = v.func; ex.ctrl = v.ctrl;
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ea, eb;
        logic [4:0]  ed;
        ea = ex.ctrl[4] ? {27'd0, ex.shamt} : ex.rs_data;
        eb = ex.ctrl[5] ? ex.imm : ex.rt_data;
        ed = ex.ctrl[6] ? ex.rd : ex.rt;
        chk({tag, ".A"}, o_A, ea);
        chk({tag, ".B"}, o_B, eb);
        chk({tag, ".rt_data"}, o_rt_data, ex.rt_data);
        chk({tag, ".dst"}, 32'(o_dst), 32'(ed));
        chk({tag, ".ALUop"}, 32'(o_ALUop), 32'(ex.alu));
        chk({tag, ".func"}, 32'(o_func), 32'(ex.func));
        chk({tag, ".mem"}, 32'(o_mem_ctrl), 32'(ex.ctrl[3:0]));
        chk({tag, ".valid"}, 32'(o_valid), 32'(ex.valid));
        chk({tag, ".cnt"}, 32'(o_bubble_cnt), m_cnt);
    endtask

    task automatic drive(input vec_t v);
        i_enable = v.en; i_flush = v.fl; i_rs_data = v.rs_data; i_rt_data = v.rt_data;
        i_imm = v.imm; i_shamt = v.shamt; i_rs = v.rs; i_rt = v.rt; i_rd = v.rd;
        i_use_rs = v.use_rs; i_use_rt = v.use_rt; i_ALUop = v.alu; i_func = v.func;
        i_ctrl = v.ctrl;
    endtask

    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        bit s;
        drive(v);
        @(negedge i_clk);
        s = model_stall(v);
        chk({tag, ".stall"}, 32'(o_stall), use_tbl ? 32'(v.x_stall) : 32'(s));
        @(posedge i_clk);
        model_edge(v, s);
        #1;
        if (use_tbl) begin
            chk({tag, ".A"}, o_A, v.x_a);
            chk({tag, ".B"}, o_B, v.x_b);
            chk({tag, ".dst"}, 32'(o_dst), 32'(v.x_dst));
            chk({tag, ".mem"}, 32'(o_mem_ctrl), 32'(v.x_mem));
            chk({tag, ".valid"}, 32'(o_valid), 32'(v.x_valid));
            chk({tag, ".cnt"}, 32'(o_bubble_cnt), 32'(v.x_cnt));
        end else begin
            check_model(tag);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".A"}, o_A, 32'd0);
        chk({tag, ".B"}, o_B, 32'd0);
        chk({tag, ".rt_data"}, o_rt_data, 32'd0);
        chk({tag, ".dst"}, 32'(o_dst), 32'd0);
        chk({tag, ".ALUop"}, 32'(o_ALUop), 32'd0);
        chk({tag, ".func"}, 32'(o_func), 32'd0);
        chk({tag, ".mem"}, 32'(o_mem_ctrl), 32'd0);
        chk({tag, ".valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".stall"}, 32'(o_stall), 32'd0);
        chk({tag, ".cnt"}, 32'(o_bubble_cnt), 32'd0);
    endtask

    vec_t tbl[15];
    vec_t v;

    initial begin
        //          en    fl    rs_data        rt_data       imm            sh     rs     rt     rd     urs   urt   alu   func        ctrl          stall A             B              dst    mem      vld   cnt
        tbl[0]  = '{1'b1, 1'b0, 32'h1,   32'h5,    32'h0,         5'd0, 5'd1, 5'd2, 5'd3,  1'b1, 1'b1, 4'h0, 6'b100000, 7'b1000001, 1'b0, 32'h1,   32'h5,         5'd3,  4'b0001, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'h77,  32'h1F,   32'h0,         5'd4, 5'd0, 5'd4, 5'd9,  1'b0, 1'b1, 4'h0, 6'h00,     7'b1010001, 1'b0, 32'h4,   32'h1F,        5'd9,  4'b0001, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'hA,   32'h1F,   32'hFFFFFFF0,  5'd0, 5'd1, 5'd6, 5'd0,  1'b1, 1'b0, 4'h2, 6'h00,     7'b0100001, 1'b0, 32'hA,   32'hFFFFFFF0,  5'd6,  4'b0001, 1'b1, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'h100, 32'h0,    32'h4,         5'd0, 5'd2, 5'd8, 5'd0,  1'b1, 1'b0, 4'h1, 6'h00,     7'b0101011, 1'b0, 32'h100, 32'h4,         5'd8,  4'b1011, 1'b1, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, 32'h11,  32'h22,   32'h0,         5'd0, 5'd8, 5'd3, 5'd12, 1'b1, 1'b1, 4'h0, 6'h20,     7'b1000001, 1'b1, 32'h0,   32'h0,         5'd0,  4'b0000, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 1'b0, 32'h11,  32'h22,   32'h0,         5'd0, 5'd8, 5'd3, 5'd12, 1'b1, 1'b1, 4'h0, 6'h20,     7'b1000001, 1'b0, 32'h11,  32'h22,        5'd12, 4'b0001, 1'b1, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, 32'h200, 32'h0,    32'h8,         5'd0, 5'd1, 5'd7, 5'd0,  1'b1, 1'b0, 4'h1, 6'h00,     7'b0101011, 1'b0, 32'h200, 32'h8,         5'd7,  4'b1011, 1'b1, 16'd1};
        tbl[7]  = '{1'b1, 1'b1, 32'h5,   32'h6,    32'h0,         5'd0, 5'd0, 5'd7, 5'd2,  1'b0, 1'b1, 4'h0, 6'h20,     7'b1000001, 1'b0, 32'h0,   32'h0,         5'd0,  4'b0000, 1'b0, 16'd2};
        tbl[8]  = '{1'b1, 1'b0, 32'h300, 32'h0,    32'hC,         5'd0, 5'd0, 5'd5, 5'd0,  1'b1, 1'b0, 4'h1, 6'h00,     7'b0101011, 1'b0, 32'h300, 32'hC,         5'd5,  4'b1011, 1'b1, 16'd2};
        tbl[9]  = '{1'b0, 1'b0, 32'hDEAD,32'hBEEF, 32'h1234,      5'd7, 5'd5, 5'd1, 5'd2,  1'b1, 1'b0, 4'h3, 6'h3F,     7'b1111111, 1'b1, 32'h300, 32'hC,         5'd5,  4'b1011, 1'b1, 16'd2};
        tbl[10] = '{1'b0, 1'b0, 32'h1,   32'h2,    32'h3,         5'd1, 5'd4, 5'd5, 5'd6,  1'b1, 1'b1, 4'h4, 6'h01,     7'b0000000, 1'b1, 32'h300, 32'hC,         5'd5,  4'b1011, 1'b1, 16'd2};
        tbl[11] = '{1'b0, 1'b1, 32'h9,   32'h8,    32'h7,         5'd2, 5'd6, 5'd9, 5'd3,  1'b1, 1'b1, 4'h5, 6'h02,     7'b0101011, 1'b0, 32'h300, 32'hC,         5'd5,  4'b1011, 1'b1, 16'd2};
        tbl[12] = '{1'b1, 1'b0, 32'hA,   32'hB,    32'h0,         5'd0, 5'd1, 5'd2, 5'd4,  1'b1, 1'b1, 4'h0, 6'h20,     7'b1000001, 1'b0, 32'hA,   32'hB,         5'd4,  4'b0001, 1'b1, 16'd2};
        tbl[13] = '{1'b1, 1'b0, 32'h40,  32'h0,    32'h0,         5'd0, 5'd3, 5'd0, 5'd0,  1'b1, 1'b0, 4'h1, 6'h00,     7'b0101011, 1'b0, 32'h40,  32'h0,         5'd0,  4'b1011, 1'b1, 16'd2};
        tbl[14] = '{1'b1, 1'b0, 32'h1,   32'h2,    32'h0,         5'd0, 5'd0, 5'd0, 5'd1,  1'b1, 1'b1, 4'h0, 6'h20,     7'b1000001, 1'b0, 32'h1,   32'h2,         5'd1,  4'b0001, 1'b1, 16'd2};

        // Reset with every input driven nonzero.
        i_reset_n = 1'b1;
        i_enable = 1'b1; i_flush = 1'b0; i_rs_data = '1; i_rt_data = '1; i_imm = '1;
        i_shamt = '1; i_rs = '1; i_rt = '1; i_rd = '1; i_use_rs = 1'b1; i_use_rt = 1'b1;
        i_ALUop = '1; i_func = '1; i_ctrl = '1;
        ex = empty_slot();
        m_cnt = 0;
        #2 i_reset_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge i_clk); #1;
        check_all_zero("rst_held");
        #2 i_reset_n = 1'b1;

        for (int i = 0; i < 15; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

        for (int i = 0; i < 400; i++) begin
            v = tbl[0];
            v.en      = ($urandom_range(0, 5) != 0);
            v.fl      = ($urandom_range(0, 7) == 0);
            v.rs_data = $urandom; v.rt_data = $urandom; v.imm = $urandom;
            v.shamt   = 5'($urandom);
            v.rs      = 5'($urandom_range(0, 5));
            v.rt      = 5'($urandom_range(0, 5));
            v.rd      = 5'($urandom);
            v.use_rs  = 1'($urandom);
            v.use_rt  = 1'($urandom);
            v.alu     = 4'($urandom_range(0, 6));
            v.func    = 6'($urandom);
            v.ctrl    = 7'($urandom);
            step(v, 1'b0, "rand");
        end

        // Mid-cycle reset clears state immediately; next enabled edge loads normally.
        #2 i_reset_n = 1'b0;
        ex = empty_slot();
        m_cnt = 0;
        #1 check_all_zero("rst_mid");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        step(tbl[3], 1'b0, "post_rst_load");
        step(tbl[4], 1'b0, "post_rst_stall");

        // Counter saturation with a long run of flushes.
        v = tbl[0];
        v.fl = 1'b1;
        drive(v);
        repeat (65535) @(posedge i_clk);
        #1;
        chk("sat_reach", 32'(o_bubble_cnt), 32'hFFFF);
        repeat (5) @(posedge i_clk);
        #1;
        chk("sat_hold", 32'(o_bubble_cnt), 32'hFFFF);
        chk("sat_valid", 32'(o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
